rom_fetch_sequencer: RTL and testbench
======================================

# rom_fetch_sequencer

Sequences block reads from the 16-port read-only coefficient ROM. It accepts a (base, length) request and drives all 16 ROM address lanes each cycle. Each ROM response is registered into a 16-lane beat with a lane mask, delivered over a valid/ready stream. It sits between the predictor control logic and the ROM and owns every ROM address lane.

## Interface
Parameters:
- DATAWIDTH, 2: bits per ROM word.
- DEPTHBITS, 3: ROM address width. DATADEPTH = 1 << DEPTHBITS.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  high exactly when the FSM is in IDLE.
- req_base  in  DEPTHBITS  first word address.
- req_len  in  DEPTHBITS+1  word count, 0..DATADEPTH. Larger values are clamped to DATADEPTH.
- rom_addr  out  16*DEPTHBITS  lane k address at [k*DEPTHBITS +: DEPTHBITS], wired to ROM port k.
- rom_data  in  16*DATAWIDTH  lane k word, combinational response to rom_addr lane k.
- beat_valid  out  1  beat register holds an undelivered beat.
- beat_ready  in  1  consumer accepts beat.
- beat_data  out  16*DATAWIDTH  registered lane words; masked lanes are zero.
- beat_mask  out  16  bit k set means lane k carries a requested word.
- beat_last  out  1  final beat of the request.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse after the last beat handshake, or after accepting a zero-length request.

## Operation
- FSM states are IDLE, FETCH and OUT.
- Internal registers: cursor (DEPTHBITS), remaining (DEPTHBITS+1).
- IDLE:
  - If req_valid is high: cursor <= req_base, remaining <= effective length (see Configuration).
  - If effective length is 0: go directly to IDLE with done = 1 on the next cycle.
  - Otherwise go to FETCH.
- Lane addressing: rom_addr lane k = cursor + k, modulo DATADEPTH, in every state.
- Lane masking: lane k is valid when k < remaining. On capture, the beat register loads rom_data for valid lanes and 0 for masked lanes. beat_mask captures the valid-lane vector. beat_last captures (remaining <= 16).
- FETCH:
  - Capture the beat.
  - remaining <= remaining - min(16, remaining); cursor <= cursor + 16.
  - Go to OUT with beat_valid = 1.
- OUT:
  - Hold beat_data, beat_mask and beat_last stable while beat_valid && !beat_ready.
  - On handshake with beat_last = 0: capture the next beat at the same edge, with no bubble, and stay in OUT.
  - On handshake with beat_last = 1: beat_valid <= 0, done <= 1, go to IDLE.
- done is high for exactly one cycle. A new request may be accepted in the cycle done is high.
- req_* inputs are ignored outside IDLE. Request fields are sampled only at the acceptance edge.
- rst mid-transfer:
  - FSM goes to IDLE and the current beat is dropped.
  - No done pulse is generated.
  - The next request starts clean.
- Reset values: req_ready 1; beat_valid 0; beat_data 0; beat_mask 0; beat_last 0; busy 0; done 0; cursor 0; remaining 0.

## Timing
- Acceptance edge T. The first beat is valid after edge T+1 (one FETCH cycle).
- With beat_ready held high, beats arrive on consecutive cycles.
- A request of N words produces ceil(N/16) beats.
- For beat_ready held high, done is high in the cycle after the last handshake. The total is ceil(N/16) + 2 cycles from acceptance to the done pulse.
- The zero-length request is the exception: done pulses in the cycle after acceptance, with no beats.
- Back-to-back requests incur at least one idle cycle between beats, because a request accepted during the done cycle goes through FETCH.
- rom_addr is combinational from cursor. rom_data must settle within one cycle; the ROM is combinational.

## Configuration
- ROMSEQ_WRAP_EN defined:
  - Effective length = min(req_len, DATADEPTH).
  - Reads past DATADEPTH-1 wrap to address 0.
- ROMSEQ_WRAP_EN undefined:
  - Effective length = min(req_len, DATADEPTH - req_base).
  - Reads never cross the top of the ROM; there is no wrap.

## Test plan
The ROM model returns word i = i + 8'h40, with DATAWIDTH=8 and DEPTHBITS=5 (32 words).

- Multi-beat read: base 0, len 20, beat_ready high.
  - Beat 0: mask 16'hFFFF, lanes 0x40..0x4F, last 0.
  - Beat 1: mask 16'h000F, lanes 0x50..0x53, lanes 4-15 zero, last 1.
  - done pulses at acceptance + 4 cycles.
- Backpressure: same request, beat_ready low for 5 cycles after beat 0 appears.
  - beat_data and beat_mask stay stable.
  - No second beat appears.
  - done stays low until beat 1 is accepted.
- Wrap boundary: base 30, len 4.
  - With ROMSEQ_WRAP_EN: a single beat, mask 16'h000F, data 0x5E, 0x5F, 0x40, 0x41.
  - Without ROMSEQ_WRAP_EN: mask 16'h0003, data 0x5E, 0x5F, lanes 2-15 zero.
- Zero and over-length requests:
  - len 0: no beat; done pulses the cycle after acceptance.
  - len 40 at base 0 (out of range): clamped to 32 words; two full beats, mask 16'hFFFF each.
- Reset mid-transfer: rst asserted while beat 0 is pending.
  - Next cycle: beat_valid 0, busy 0, req_ready 1; done never pulses.
  - A following request of base 5, len 1 returns a single beat with data 0x45 in lane 0 and mask 16'h0001.
- Request during done: assert req_valid in the done cycle of the previous transfer.
  - The request is accepted in that cycle.
  - Its first beat appears two cycles later.

Source files
------------

// File: rtl/rom_fetch_sequencer_if.sv
// ============================================================================
// Module      : rom_fetch_sequencer_if
// Description : Request, ROM-lane and beat-stream signals of the ROM fetch
//               sequencer, bundled with sequencer (slave) and client (master)
//               views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rom_fetch_sequencer_if #(
    parameter int DATAWIDTH = 2,
    parameter int DEPTHBITS = 3
);
    // Request channel
    logic                      req_valid;
    logic                      req_ready;
    logic [DEPTHBITS-1:0]      req_base;
    logic [DEPTHBITS:0]        req_len;

    // ROM lanes: 16 address outputs, 16 combinational word responses
    logic [16*DEPTHBITS-1:0]   rom_addr;
    logic [16*DATAWIDTH-1:0]   rom_data;

    // Beat stream
    logic                      beat_valid;
    logic                      beat_ready;
    logic [16*DATAWIDTH-1:0]   beat_data;
    logic [15:0]               beat_mask;
    logic                      beat_last;

    // Status
    logic                      busy;
    logic                      done;

    modport slave (
        input  req_valid,
        input  req_base,
        input  req_len,
        input  rom_data,
        input  beat_ready,
        output req_ready,
        output rom_addr,
        output beat_valid,
        output beat_data,
        output beat_mask,
        output beat_last,
        output busy,
        output done
    );

    modport master (
        output req_valid,
        output req_base,
        output req_len,
        output rom_data,
        output beat_ready,
        input  req_ready,
        input  rom_addr,
        input  beat_valid,
        input  beat_data,
        input  beat_mask,
        input  beat_last,
        input  busy,
        input  done
    );

endinterface

`default_nettype wire

// File: rtl/rom_fetch_sequencer.sv
// ============================================================================
// Module      : rom_fetch_sequencer
// Description : Turns (base, length) requests into 16-lane beats read from a
//               16-port combinational ROM. Define ROMSEQ_WRAP_EN to let reads
//               wrap past the top of the ROM; otherwise they stop there.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_fetch_sequencer #(
    parameter int DATAWIDTH = 2,
    parameter int DEPTHBITS = 3
) (
    input  wire                    clk,
    input  wire                    rst,
    rom_fetch_sequencer_if.slave   bus
);

    localparam int unsigned c_lanes = 16;
    localparam int unsigned c_depth = 1 << DEPTHBITS;
    localparam int          c_rw    = DEPTHBITS + 1;

    localparam logic [DEPTHBITS-1:0] c_step      = DEPTHBITS'(c_lanes);
    localparam logic [c_rw-1:0]      c_depth_len = c_rw'(c_depth);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;

    logic [DEPTHBITS-1:0]        r_cursor;
    logic [c_rw-1:0]             r_remaining;

    logic                        r_beat_valid;
    logic [16*DATAWIDTH-1:0]     r_beat_data;
    logic [15:0]                 r_beat_mask;
    logic                        r_beat_last;
    logic                        r_done;

    logic [c_rw-1:0]             w_len_clamp;
    logic [c_rw-1:0]             w_eff_len;
    logic                        w_zero_len;

    logic [16*DEPTHBITS-1:0]     w_rom_addr;
    logic [15:0]                 w_lane_valid;
    logic [16*DATAWIDTH-1:0]     w_beat_next;
    logic [31:0]                 w_rem32;
    logic [c_rw-1:0]             w_rem_after;
    logic                        w_last_next;

    logic                        w_handshake;
    logic                        w_load_req;
    logic                        w_capture;
    logic                        w_finish;
    logic                        w_done_next;

    // ------------------------------------------------------------------------
    // Effective request length
    // ------------------------------------------------------------------------
    always_comb begin
        w_len_clamp = (32'(bus.req_len) > c_depth) ? c_depth_len : bus.req_len;
`ifdef ROMSEQ_WRAP_EN
        w_eff_len = w_len_clamp;
`else
        // Without wrap the read may only run up to the last ROM word.
        if (w_len_clamp > (c_depth_len - c_rw'(bus.req_base))) begin
            w_eff_len = c_depth_len - c_rw'(bus.req_base);
        end else begin
            w_eff_len = w_len_clamp;
        end
`endif
        w_zero_len = (w_eff_len == '0);
    end

    // ------------------------------------------------------------------------
    // Lane addressing, masking and next-beat assembly
    // ------------------------------------------------------------------------
    always_comb begin
        w_rom_addr   = '0;
        w_lane_valid = '0;
        w_beat_next  = '0;
        w_rem32      = 32'(r_remaining);
        for (int unsigned k = 0; k < c_lanes; k++) begin
            // Address arithmetic wraps naturally at DEPTHBITS width.
            w_rom_addr[k*DEPTHBITS +: DEPTHBITS] = r_cursor + DEPTHBITS'(k);
            w_lane_valid[k] = (w_rem32 > k);
            if (w_rem32 > k) begin
                w_beat_next[k*DATAWIDTH +: DATAWIDTH] =
                    bus.rom_data[k*DATAWIDTH +: DATAWIDTH];
            end
        end
        w_last_next = (w_rem32 <= 32'(c_lanes));
        w_rem_after = (w_rem32 > 32'(c_lanes)) ? c_rw'(w_rem32 - 32'(c_lanes))
                                               : '0;
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_req   = 1'b0;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        w_done_next  = 1'b0;
        w_handshake  = r_beat_valid && bus.beat_ready;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_load_req = 1'b1;
                    if (w_zero_len) begin
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                w_capture    = 1'b1;
                w_state_next = S_OUT;
            end
            S_OUT: begin
                if (w_handshake) begin
                    if (r_beat_last) begin
                        w_finish     = 1'b1;
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        // Refill on the accepting edge so beats run bubble-free.
                        w_capture = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cursor     <= '0;
            r_remaining  <= '0;
            r_beat_valid <= 1'b0;
            r_beat_data  <= '0;
            r_beat_mask  <= '0;
            r_beat_last  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_done_next;

            if (w_load_req) begin
                r_cursor    <= bus.req_base;
                r_remaining <= w_eff_len;
            end

            if (w_capture) begin
                r_beat_data  <= w_beat_next;
                r_beat_mask  <= w_lane_valid;
                r_beat_last  <= w_last_next;
                r_beat_valid <= 1'b1;
                r_remaining  <= w_rem_after;
                r_cursor     <= r_cursor + c_step;
            end

            if (w_finish) begin
                r_beat_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.rom_addr   = w_rom_addr;
    assign bus.beat_valid = r_beat_valid;
    assign bus.beat_data  = r_beat_data;
    assign bus.beat_mask  = r_beat_mask;
    assign bus.beat_last  = r_beat_last;
    assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rom_fetch_sequencer.sv
// ============================================================================
// Module      : tb_rom_fetch_sequencer
// Description : Directed self-checking bench for rom_fetch_sequencer with a
//               32-word ROM returning word i = i + 8'h40.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_fetch_sequencer;

    localparam int DW = 8;
    localparam int DB = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rom_fetch_sequencer_if #(.DATAWIDTH(DW), .DEPTHBITS(DB)) bus ();

    rom_fetch_sequencer #(.DATAWIDTH(DW), .DEPTHBITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16*DW-1:0] rom_resp;
    always_comb begin
        rom_resp = '0;
        for (int k = 0; k < 16; k++) begin
            rom_resp[k*DW +: DW] = {3'b000, bus.rom_addr[k*DB +: DB]} + 8'h40;
        end
    end
    assign bus.rom_data = rom_resp;

    // Expected beat: nvalid words starting at address start, rest zero.
    function automatic logic [127:0] exp_beat(input int start, input int nvalid);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < nvalid) v[i*8 +: 8] = 8'(((start + i) % 32) + 'h40);
        end
        return v;
    endfunction

    task automatic issue_req(input int base, input int len);
        bus.req_valid = 1'b1;
        bus.req_base  = 5'(base);
        bus.req_len   = 6'(len);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
        checks++; if (bus.beat_valid !== 1'b0) begin errors++; $display("FAIL reset_beat_valid got %b exp 0", bus.beat_valid); end
        checks++; if (bus.beat_data !== '0) begin errors++; $display("FAIL reset_beat_data got %h exp 0", bus.beat_data); end
        checks++; if (bus.beat_mask !== 16'h0000) begin errors++; $display("FAIL reset_beat_mask got %h exp 0000", bus.beat_mask); end
        checks++; if (bus.beat_last !== 1'b0) begin errors++; $display("FAIL reset_beat_last got %b exp 0", bus.beat_last); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        rst = 1'b0;
    endtask

    task automatic test_multi_beat();
        @(negedge clk); issue_req(0, 20);
        @(negedge clk); bus.req_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL multi_fetch_status got busy=%b ready=%b exp busy=1 ready=0", bus.busy, bus.req_ready); end
        checks++; if (bus.beat_valid !== 1'b0) begin errors++; $display("FAIL multi_fetch_valid got %b exp 0", bus.beat_valid); end
        @(negedge clk);
        checks++; if (bus.beat_valid !== 1'b1 || bus.beat_last !== 1'b0) begin errors++; $display("FAIL multi_b0_ctl got valid=%b last=%b exp valid=1 last=0", bus.beat_valid, bus.beat_last); end
        checks++; if (bus.beat_mask !== 16'hFFFF) begin errors++; $display("FAIL multi_b0_mask got %h exp FFFF", bus.beat_mask); end
        checks++; if (bus.beat_data !== exp_beat(0, 16)) begin errors++; $display("FAIL multi_b0_data got %h exp %h", bus.beat_data, exp_beat(0, 16)); end
        @(negedge clk);
        checks++; if (bus.beat_valid !== 1'b1 || bus.beat_last !== 1'b1) begin errors++; $display("FAIL multi_b1_ctl got valid=%b last=%b exp valid=1 last=1", bus.beat_valid, bus.beat_last); end
        checks++; if (bus.beat_mask !== 16'h000F) begin errors++; $display("FAIL multi_b1_mask got %h exp 000F", bus.beat_mask); end
        checks++; if (bus.beat_data !== exp_beat(16, 4)) begin errors++; $display("FAIL multi_b1_data got %h exp %h", bus.beat_data, exp_beat(16, 4)); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multi_done_early got %b exp 0", bus.done); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1 || bus.beat_valid !== 1'b0) begin errors++; $display("FAIL multi_done got done=%b valid=%b exp done=1 valid=0", bus.done, bus.beat_valid); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multi_done_width got %b exp 0", bus.done); end
    endtask

    task automatic test_backpressure();
        @(negedge clk); bus.beat_ready = 1'b0; issue_req(0, 20);
        @(negedge clk); bus.req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.beat_valid !== 1'b1 || bus.beat_mask !== 16'hFFFF || bus.beat_last !== 1'b0) begin errors++; $display("FAIL bp_hold_ctl[%0d] got valid=%b mask=%h last=%b exp 1 FFFF 0", c, bus.beat_valid, bus.beat_mask, bus.beat_last); end
            checks++; if (bus.beat_data !== exp_beat(0, 16)) begin errors++; $display("FAIL bp_hold_data[%0d] got %h exp %h", c, bus.beat_data, exp_beat(0, 16)); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL bp_done[%0d] got %b exp 0", c, bus.done); end
        end
        bus.beat_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.beat_mask !== 16'h000F || bus.beat_data !== exp_beat(16, 4)) begin errors++; $display("FAIL bp_b1 got mask=%h data=%h exp 000F %h", bus.beat_mask, bus.beat_data, exp_beat(16, 4)); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL bp_done_b1 got %b exp 0", bus.done); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", bus.done); end
    endtask

    task automatic test_wrap();
        logic [15:0]  m;
        logic [127:0] d;
`ifdef ROMSEQ_WRAP_EN
        m = 16'h000F; d = exp_beat(30, 4);
`else
        m = 16'h0003; d = exp_beat(30, 2);
`endif
        @(negedge clk); issue_req(30, 4);
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.beat_valid !== 1'b1 || bus.beat_last !== 1'b1) begin errors++; $display("FAIL wrap_ctl got valid=%b last=%b exp 1 1", bus.beat_valid, bus.beat_last); end
        checks++; if (bus.beat_mask !== m) begin errors++; $display("FAIL wrap_mask got %h exp %h", bus.beat_mask, m); end
        checks++; if (bus.beat_data !== d) begin errors++; $display("FAIL wrap_data got %h exp %h", bus.beat_data, d); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", bus.done); end
    endtask

    task automatic test_zero_len();
        @(negedge clk); issue_req(3, 0);
        @(negedge clk); bus.req_valid = 1'b0;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", bus.done); end
        checks++; if (bus.beat_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL zero_status got valid=%b busy=%b ready=%b exp 0 0 1", bus.beat_valid, bus.busy, bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.beat_valid !== 1'b0) begin errors++; $display("FAIL zero_after got done=%b valid=%b exp 0 0", bus.done, bus.beat_valid); end
    endtask

    task automatic test_over_len();
        @(negedge clk); issue_req(0, 40);
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.beat_mask !== 16'hFFFF || bus.beat_last !== 1'b0) begin errors++; $display("FAIL over_b0_ctl got mask=%h last=%b exp FFFF 0", bus.beat_mask, bus.beat_last); end
        checks++; if (bus.beat_data !== exp_beat(0, 16)) begin errors++; $display("FAIL over_b0_data got %h exp %h", bus.beat_data, exp_beat(0, 16)); end
        @(negedge clk);
        checks++; if (bus.beat_mask !== 16'hFFFF || bus.beat_last !== 1'b1) begin errors++; $display("FAIL over_b1_ctl got mask=%h last=%b exp FFFF 1", bus.beat_mask, bus.beat_last); end
        checks++; if (bus.beat_data !== exp_beat(16, 16)) begin errors++; $display("FAIL over_b1_data got %h exp %h", bus.beat_data, exp_beat(16, 16)); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1 || bus.beat_valid !== 1'b0) begin errors++; $display("FAIL over_done got done=%b valid=%b exp 1 0", bus.done, bus.beat_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); bus.beat_ready = 1'b0; issue_req(0, 20);
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.beat_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b exp 1", bus.beat_valid); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (bus.beat_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state got valid=%b busy=%b ready=%b exp 0 0 1", bus.beat_valid, bus.busy, bus.req_ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", bus.done); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done[%0d] got %b exp 0", c, bus.done); end
        end
        bus.beat_ready = 1'b1; issue_req(5, 1);
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.beat_valid !== 1'b1 || bus.beat_mask !== 16'h0001 || bus.beat_last !== 1'b1) begin errors++; $display("FAIL rstmid_next_ctl got valid=%b mask=%h last=%b exp 1 0001 1", bus.beat_valid, bus.beat_mask, bus.beat_last); end
        checks++; if (bus.beat_data !== exp_beat(5, 1)) begin errors++; $display("FAIL rstmid_next_data got %h exp %h", bus.beat_data, exp_beat(5, 1)); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rstmid_next_done got %b exp 1", bus.done); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); issue_req(0, 4);
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.beat_mask !== 16'h000F || bus.beat_data !== exp_beat(0, 4)) begin errors++; $display("FAIL b2b_first got mask=%h data=%h exp 000F %h", bus.beat_mask, bus.beat_data, exp_beat(0, 4)); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_done got done=%b ready=%b exp 1 1", bus.done, bus.req_ready); end
        issue_req(8, 2);
        @(negedge clk); bus.req_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.beat_valid !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_fetch got busy=%b valid=%b done=%b exp 1 0 0", bus.busy, bus.beat_valid, bus.done); end
        @(negedge clk);
        checks++; if (bus.beat_valid !== 1'b1 || bus.beat_mask !== 16'h0003 || bus.beat_last !== 1'b1) begin errors++; $display("FAIL b2b_second_ctl got valid=%b mask=%h last=%b exp 1 0003 1", bus.beat_valid, bus.beat_mask, bus.beat_last); end
        checks++; if (bus.beat_data !== exp_beat(8, 2)) begin errors++; $display("FAIL b2b_second_data got %h exp %h", bus.beat_data, exp_beat(8, 2)); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", bus.done); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_base   = '0;
        bus.req_len    = '0;
        bus.beat_ready = 1'b1;

        test_reset();
        test_multi_beat();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_over_len();
        test_reset_mid();
        test_back_to_back();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
